// File: rtl/sw_out_arb.sv
// rtl/sw_out_arb.sv - per-output-port round-robin packet arbiter
//
// Purpose: grants one output link of the packet switch to one input-port
// controller at a time. Requests are arbitrated round-robin, with the last
// winner given lowest priority. A grant is held for a whole packet, up to
// and including its TAIL flit. The block also drives the crossbar select.
//
// Optional feature: define SW_ARB_TIMEOUT_EN to add a hold timeout and the
// tmo port. With the timeout, a grant that sees MAXHOLD consecutive cycles
// without a flit from its owner is force-released.
//
// Ports:
//   clk    clock, all state on posedge
//   rst    synchronous reset, active-high
//   req    [NIN]   request from input i, level, held until packet done
//   vld    [NIN]   input i presents a flit this cycle
//   ptype  [2*NIN] flit type of input i at [2i+1:2i]
//   ack    [NIN]   one-hot grant (zero when idle)
//   sel    [SELW]  index of granted input (0 when idle)
//   ovld   flit forwarded to the output link this cycle
//   busy   grant held
//   tmo    one-cycle pulse after a forced release (SW_ARB_TIMEOUT_EN only)

module sw_out_arb #(
  parameter int NIN     = 4,
  parameter int MAXHOLD = 64,
  localparam int SELW   = (NIN > 1) ? $clog2(NIN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NIN-1:0]    req,
  input  logic [NIN-1:0]    vld,
  input  logic [2*NIN-1:0]  ptype,
  output logic [NIN-1:0]    ack,
  output logic [SELW-1:0]   sel,
  output logic              ovld,
  output logic              busy
`ifdef SW_ARB_TIMEOUT_EN
  ,
  output logic              tmo
`endif
);

  // Flit type codes.
  localparam logic [1:0] PT_TAIL = 2'b10;

  if (NIN < 2 || NIN > 16 || MAXHOLD < 1) begin : g_param_check
    $error("sw_out_arb: NIN must be 2..16 and MAXHOLD at least 1");
  end

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state, state_n;
  logic [SELW-1:0] g, g_n;        // current grant owner
  logic [SELW-1:0] ptr, ptr_n;    // round-robin start point
  logic [NIN-1:0]  elig;          // requesters allowed in this arbitration
  logic            found;
  logic [SELW-1:0] win;
  logic [SELW-1:0] idx;
  logic            rel_tail, rel_wd, rel_to, rel;

`ifdef SW_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAXHOLD + 1);
  logic [CW-1:0] cnt, cnt_n;
  logic          tmo_q, tmo_n;
`endif

  // Release conditions for the current holder.
  always_comb begin
    rel_tail = (state == HOLD) && vld[g] && (ptype[{g, 1'b0} +: 2] == PT_TAIL);
    rel_wd   = (state == HOLD) && !req[g];
`ifdef SW_ARB_TIMEOUT_EN
    // Release on the edge that completes the MAXHOLD-th idle cycle.
    rel_to   = (state == HOLD) && !vld[g] && (cnt == CW'(MAXHOLD - 1));
`else
    rel_to   = 1'b0;
`endif
    rel      = rel_tail || rel_wd || rel_to;
    // A timed-out owner still has req set but must not win straight back.
    elig     = req;
    if (rel_to) elig[g] = 1'b0;
  end

  // Round-robin search of elig starting at ptr, wrapping at NIN-1.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NIN; i++) begin
      idx = SELW'((int'(ptr) + i) % NIN);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      g     <= '0;
      ptr   <= '0;
`ifdef SW_ARB_TIMEOUT_EN
      cnt   <= '0;
      tmo_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      g     <= g_n;
      ptr   <= ptr_n;
`ifdef SW_ARB_TIMEOUT_EN
      cnt   <= cnt_n;
      tmo_q <= tmo_n;
`endif
    end
  end

  // Next-state logic. A release re-arbitrates in the same edge, so
  // back-to-back packets from different inputs see no idle bubble.
  always_comb begin
    state_n = state;
    g_n     = g;
    ptr_n   = ptr;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = HOLD;
          g_n     = win;
          ptr_n   = (win == SELW'(NIN - 1)) ? '0 : win + 1'b1;
        end
      end
      HOLD: begin
        if (rel) begin
          if (found) begin
            g_n   = win;
            ptr_n = (win == SELW'(NIN - 1)) ? '0 : win + 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef SW_ARB_TIMEOUT_EN
  // The idle counter restarts on every new grant and on every owner flit.
  always_comb begin
    cnt_n = '0;
    if (state == HOLD && !rel && !vld[g]) cnt_n = cnt + 1'b1;
    // A simultaneous withdrawal is an ordinary release, not a forced one.
    tmo_n = rel_to && req[g];
  end
`endif

  // Outputs decoded from registered state.
  always_comb begin
    busy = (state == HOLD);
    sel  = busy ? g : '0;
    ack  = busy ? (NIN'(1) << g) : '0;
    ovld = busy && vld[sel];
`ifdef SW_ARB_TIMEOUT_EN
    tmo  = tmo_q;
`endif
  end

endmodule

// File: tb/tb_sw_out_arb.sv
// tb/tb_sw_out_arb.sv - randomized and directed bench for sw_out_arb
module tb_sw_out_arb;

  localparam logic [1:0] BODY = 2'b00;
  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] TAIL = 2'b10;
  localparam int MH = 8;
`ifdef SW_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [3:0] req_a = '0, vld_a = '0;
  logic [7:0] pt_a  = '0;
  logic [3:0] ack_a;
  logic [1:0] sel_a;
  logic       ovld_a, busy_a, tmo_a;

  logic [2:0] req_b = '0, vld_b = '0;
  logic [5:0] pt_b  = '0;
  logic [2:0] ack_b;
  logic [1:0] sel_b;
  logic       ovld_b, busy_b, tmo_b;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  sw_out_arb #(.NIN(4), .MAXHOLD(MH)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .vld(vld_a), .ptype(pt_a),
    .ack(ack_a), .sel(sel_a), .ovld(ovld_a), .busy(busy_a)
`ifdef SW_ARB_TIMEOUT_EN
    , .tmo(tmo_a)
`endif
  );

  sw_out_arb #(.NIN(3), .MAXHOLD(MH)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .vld(vld_b), .ptype(pt_b),
    .ack(ack_b), .sel(sel_b), .ovld(ovld_b), .busy(busy_b)
`ifdef SW_ARB_TIMEOUT_EN
    , .tmo(tmo_b)
`endif
  );

`ifndef SW_ARB_TIMEOUT_EN
  assign tmo_a = 1'b0;
  assign tmo_b = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 = idle), rotating start point, and
  // a count of consecutive cycles the owner sent nothing.
  int own[2]  = '{-1, -1};
  int mptr[2] = '{0, 0};
  int idle[2] = '{0, 0};
  bit mtmo[2] = '{1'b0, 1'b0};

  task automatic model_step(input int k, input int n, input logic [15:0] rq,
                            input logic [15:0] vl, input logic [31:0] pt);
    logic [15:0] el;
    bit tail, wd, to, free;
    mtmo[k] = 1'b0;
    el = rq;
    free = 1'b0;
    if (own[k] < 0) begin
      free = 1'b1;
    end else begin
      tail = vl[own[k]] && (pt[2*own[k] +: 2] == TAIL);
      wd   = !rq[own[k]];
      if (vl[own[k]]) idle[k] = 0;
      else idle[k] = idle[k] + 1;
      to   = TO_EN && (idle[k] >= MH);
      if (to && !tail && !wd) begin
        el[own[k]] = 1'b0;
        mtmo[k] = 1'b1;
      end
      free = tail || wd || to;
    end
    if (free) begin
      own[k] = -1;
      for (int i = 0; i < n; i++) begin
        int c;
        c = (mptr[k] + i) % n;
        if (own[k] < 0 && el[c]) begin
          own[k]  = c;
          mptr[k] = (c + 1) % n;
          idle[k] = 0;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        own[k] = -1; mptr[k] = 0; idle[k] = 0; mtmo[k] = 1'b0;
      end
    end else begin
      model_step(0, 4, {12'b0, req_a}, {12'b0, vld_a}, {24'b0, pt_a});
      model_step(1, 3, {13'b0, req_b}, {13'b0, vld_b}, {26'b0, pt_b});
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] ea;
      logic [2:0] eb;
      int sa, sb;
      sa = (own[0] >= 0) ? own[0] : 0;
      sb = (own[1] >= 0) ? own[1] : 0;
      ea = (own[0] >= 0) ? 4'(1 << own[0]) : 4'b0;
      eb = (own[1] >= 0) ? 3'(1 << own[1]) : 3'b0;
      chk("a_ack",  ack_a,  ea);
      chk("a_sel",  sel_a,  sa);
      chk("a_busy", busy_a, own[0] >= 0);
      chk("a_ovld", ovld_a, (own[0] >= 0) && vld_a[sa]);
      chk("a_tmo",  tmo_a,  mtmo[0]);
      chk("b_ack",  ack_b,  eb);
      chk("b_sel",  sel_b,  sb);
      chk("b_busy", busy_b, own[1] >= 0);
      chk("b_ovld", ovld_b, (own[1] >= 0) && vld_b[sb]);
      chk("b_tmo",  tmo_b,  mtmo[1]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_a = '0; vld_a = '0; pt_a = '0;
    req_b = '0; vld_b = '0; pt_b = '0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] e;
    // reset with all requests asserted
    rst = 1'b1;
    req_a = 4'b1111;
    cyc();
    chk_en = 1'b1;
    chk("rst_ack0", ack_a, 4'b0000);
    chk("rst_busy0", busy_a, 1'b0);
    cyc();
    chk("rst_ack1", ack_a, 4'b0000);
    chk("rst_sel1", sel_a, 2'd0);
    rst = 1'b0;
    cyc();
    chk("first_ack", ack_a, 4'b0001);

    // single requester, three-flit packet
    do_reset();
    req_a = 4'b0100;
    cyc();
    chk("single_ack", ack_a, 4'b0100);
    vld_a = 4'b0100; pt_a = {2'b00, HEAD, 4'b0000};
    #1 chk("single_ovld_head", ovld_a, 1'b1);
    cyc();
    pt_a = {2'b00, BODY, 4'b0000};
    #1 chk("single_ovld_body", ovld_a, 1'b1);
    cyc();
    pt_a = {2'b00, TAIL, 4'b0000};
    req_a = 4'b0000;
    #1 chk("single_ovld_tail", ovld_a, 1'b1);
    cyc();
    vld_a = 4'b0000;
    #1 chk("single_ack_after", ack_a, 4'b0000);
    chk("single_busy_after", busy_a, 1'b0);

    // round robin with back-to-back single-flit packets
    do_reset();
    req_a = 4'b1111;
    cyc();
    chk("rr_first", ack_a, 4'b0001);
    vld_a = 4'b1111;
    pt_a  = {TAIL, TAIL, TAIL, TAIL};
    for (int i = 1; i <= 4; i++) begin
      cyc();
      e = 4'(1 << (i % 4));
      chk("rr_order", ack_a, e);
    end

    // withdrawal mid-packet
    do_reset();
    req_a = 4'b0010;
    cyc();
    chk("wd_grant", ack_a, 4'b0010);
    req_a = 4'b1010;
    cyc();
    chk("wd_no_preempt", ack_a, 4'b0010);
    req_a = 4'b1000;
    cyc();
    chk("wd_move", ack_a, 4'b1000);
    req_a = 4'b1111; vld_a = 4'b1000; pt_a = {TAIL, 6'b0};
    cyc();
    chk("wd_ptr_zero", ack_a, 4'b0001);

    // three-input instance, pointer at 2
    do_reset();
    req_b = 3'b010;
    cyc();
    chk("n3_grant1", ack_b, 3'b010);
    req_b = 3'b101; vld_b = 3'b010; pt_b = {2'b00, TAIL, 2'b00};
    cyc();
    chk("n3_win2", ack_b, 3'b100);
    chk("n3_sel2", sel_b, 2'd2);
    vld_b = 3'b100; pt_b = {TAIL, 4'b0000};
    cyc();
    chk("n3_win0", ack_b, 3'b001);
    chk("n3_sel0", sel_b, 2'd0);

    // held grant with no traffic
    do_reset();
    req_a = 4'b0001;
    cyc();
`ifdef SW_ARB_TIMEOUT_EN
    for (int i = 0; i < MH - 1; i++) begin
      cyc();
      chk("to_still_busy", busy_a, 1'b1);
    end
    cyc();
    chk("to_released", busy_a, 1'b0);
    chk("to_pulse", tmo_a, 1'b1);
    cyc();
    chk("to_pulse_end", tmo_a, 1'b0);
`else
    repeat (100) cyc();
    chk("hold_busy", busy_a, 1'b1);
    chk("hold_ack", ack_a, 4'b0001);
`endif

    // randomized traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      cyc();
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) req_a[b] = ~req_a[b];
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 7) == 0) req_b[b] = ~req_b[b];
      vld_a = 4'($urandom);
      vld_b = 3'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        vld_a = '0;
        vld_b = '0;
      end
      pt_a = 8'($urandom);
      pt_b = 6'($urandom);
      rst  = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0;
    cyc();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
